// File: rtl/i2c_slave_regfile.sv
// I2C slave with a 2^AW-byte register file. Supports pointer write, burst
// write and burst read with auto-increment. The pointer is kept across a
// repeated START, so a random read works. A user port gives zero-latency reads.
`timescale 1ns/1ps
module i2c_slave_regfile #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
  parameter int unsigned AW         = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [AW-1:0] usr_raddr,
  output logic [7:0]    usr_rdata
);

  localparam int unsigned Depth = 1 << AW;

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRack, StIgnore
  } state_e;

  logic [1:0]    scl_sync, sda_sync;
  logic          scl_hist, sda_hist;
  logic          scl, sda;
  logic          scl_rise, scl_fall, sda_rise, sda_fall;
  logic          start_det, stop_det;

  state_e        state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          rw;
  logic [AW-1:0] ptr;
  logic [7:0]    regs [Depth];

  logic [AW-1:0] ptr_inc;
  logic [7:0]    byte_in;
  logic [7:0]    rd_byte;
  logic [7:0]    rd_next;

  // Synchronize the bus pins and keep one cycle of history for edge detection.
  // The reset value is the idle-high bus level, so reset creates no false edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_hist <= scl_sync[1];
      sda_hist <= sda_sync[1];
    end
  end

  assign scl       = scl_sync[1];
  assign sda       = sda_sync[1];
  assign scl_rise  = scl & ~scl_hist;
  assign scl_fall  = ~scl & scl_hist;
  assign sda_rise  = sda & ~sda_hist;
  assign sda_fall  = ~sda & sda_hist;
  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;

  assign ptr_inc   = ptr + AW'(1);
  assign byte_in   = {shreg[6:0], sda};
  assign rd_byte   = regs[ptr];
  assign rd_next   = regs[ptr_inc];
  assign usr_rdata = regs[usr_raddr];

  // Protocol FSM: bits are sampled on SCL rise and SDA is changed on SCL fall.
  // START and STOP override every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      rw        <= 1'b0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
      regs      <= '{default: 8'h00};
    end else begin
      wr_strobe <= 1'b0;
      if (stop_det) begin
        state  <= StIdle;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_det) begin
        state   <= StAddr;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else begin
        unique case (state)
          StIdle: ;
          StAddr, StPtr, StWdata: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (state == StWdata && bit_cnt == 4'd7) begin
                regs[ptr] <= byte_in;
                wr_strobe <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= byte_in;
                ptr       <= ptr_inc;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (state == StAddr) begin
                if (shreg[7:1] == SLAVE_ADDR) begin
                  state  <= StAddrAck;
                  sda_oe <= 1'b1;
                  busy   <= 1'b1;
                  rw     <= shreg[0];
                end else begin
                  state <= StIgnore;
                end
              end else if (state == StPtr) begin
                ptr    <= shreg[AW-1:0];
                sda_oe <= 1'b1;
                state  <= StPtrAck;
              end else begin
                sda_oe <= 1'b1;
                state  <= StWdataAck;
              end
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              if (rw) begin
                // The fall that ends the ACK also presents the first read bit.
                sda_oe  <= ~rd_byte[7];
                shreg   <= {rd_byte[6:0], 1'b0};
                bit_cnt <= 4'd1;
                state   <= StRdata;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= StPtr;
              end
            end
          end
          StPtrAck, StWdataAck: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= StWdata;
            end
          end
          StRdata: begin
            if (scl_fall) begin
              if (bit_cnt < 4'd8) begin
                sda_oe  <= ~shreg[7];
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end else begin
                sda_oe <= 1'b0;
                state  <= StRack;
              end
            end
          end
          StRack: begin
            if (scl_rise) begin
              if (!sda) begin
                ptr     <= ptr_inc;
                shreg   <= rd_next;
                bit_cnt <= 4'd0;
                state   <= StRdata;
              end else begin
                state <= StIgnore;
              end
            end
          end
          StIgnore: sda_oe <= 1'b0;
          default:  state  <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: the bench acts as a bit-banged I2C master
// and keeps a byte-array model of the register file and the pointer.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

  localparam logic [6:0] Addr = 7'h3C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [3:0] usr_raddr = 4'd0;
  wire        sda_bus;
  logic       sda_oe, busy, wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, usr_rdata;

  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regfile #(.SLAVE_ADDR(Addr), .AW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (m_scl),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .usr_raddr (usr_raddr),
    .usr_rdata (usr_rdata)
  );

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  model_regs [16];
  logic [3:0]  model_ptr = 4'd0;
  bit          model_sync = 1'b1;
  logic [11:0] wr_q [$];
  logic [7:0]  buf_q [$];
  logic [7:0]  rd_log [$];
  logic        prev_strobe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One SCL period: 10 clk low, 10 clk high, bus sampled mid-high.
  task automatic mbit(input logic b, output logic s);
    m_sda = b;
    usr_raddr = 4'($urandom);
    tick(8);
    m_scl = 1'b1;
    tick(5);
    s = sda_bus;
    tick(5);
    m_scl = 1'b0;
    tick(2);
  endtask

  task automatic mstart();
    m_sda = 1'b1;
    tick(4);
    m_scl = 1'b1;
    tick(10);
    m_sda = 1'b0;
    tick(10);
    m_scl = 1'b0;
    tick(2);
  endtask

  task automatic mstop();
    m_sda = 1'b0;
    tick(4);
    m_scl = 1'b1;
    tick(10);
    m_sda = 1'b1;
    tick(10);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack, input bit is_data,
                           input string name);
    logic       s;
    logic [7:0] sh;
    sh = b;
    for (int i = 0; i < 8; i++) begin
      if (is_data && i == 7) begin
        model_sync = 1'b0;
        wr_q.push_back({model_ptr, b});
      end
      mbit(sh[7], s);
      check({name, " bit"}, 32'(s), 32'(sh[7]));
      sh = sh << 1;
    end
    if (is_data) begin
      model_regs[model_ptr] = b;
      model_ptr = model_ptr + 4'd1;
      model_sync = 1'b1;
    end
    mbit(1'b1, s);
    check({name, " ack"}, 32'(s), exp_ack ? 32'd0 : 32'd1);
  endtask

  task automatic recv_byte(input logic [7:0] exp, input bit m_ack, input string name);
    logic       s;
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mbit(1'b1, s);
      v = {v[6:0], s};
    end
    rd_log.push_back(v);
    check(name, 32'(v), 32'(exp));
    mbit(m_ack ? 1'b0 : 1'b1, s);
    check({name, " master ack"}, 32'(s), m_ack ? 32'd0 : 32'd1);
    if (m_ack) model_ptr = model_ptr + 4'd1;
  endtask

  task automatic post_stop();
    tick(4);
    check("busy after stop", 32'(busy), 32'd0);
    check("sda_oe after stop", 32'(sda_oe), 32'd0);
    check("write strobes outstanding", 32'(wr_q.size()), 32'd0);
  endtask

  task automatic do_write(input logic [7:0] p);
    mstart();
    send_byte({Addr, 1'b0}, 1'b1, 1'b0, "addr_w");
    check("busy after addr ack", 32'(busy), 32'd1);
    send_byte(p, 1'b1, 1'b0, "ptr");
    model_ptr = p[3:0];
    foreach (buf_q[i]) send_byte(buf_q[i], 1'b1, 1'b1, "wdata");
    mstop();
    post_stop();
  endtask

  task automatic do_read(input bit with_ptr, input logic [7:0] p, input int n);
    rd_log.delete();
    if (with_ptr) begin
      mstart();
      send_byte({Addr, 1'b0}, 1'b1, 1'b0, "addr_w");
      send_byte(p, 1'b1, 1'b0, "ptr");
      model_ptr = p[3:0];
    end
    mstart();
    send_byte({Addr, 1'b1}, 1'b1, 1'b0, "addr_r");
    check("busy after read addr", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) recv_byte(model_regs[model_ptr], i < n - 1, "rdata");
    check("sda_oe after nack", 32'(sda_oe), 32'd0);
    mstop();
    post_stop();
  endtask

  task automatic do_nomatch(input logic [6:0] a, input logic rw);
    mstart();
    send_byte({a, rw}, 1'b0, 1'b0, "addr_nomatch");
    check("busy after nomatch", 32'(busy), 32'd0);
    mstop();
    post_stop();
  endtask

  task automatic check_reg(input logic [3:0] a, input logic [7:0] exp, input string name);
    usr_raddr = a;
    #1;
    check(name, 32'(usr_rdata), 32'(exp));
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset sda_oe", 32'(sda_oe), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset wr_strobe", 32'(wr_strobe), 32'd0);
      check("reset wr_addr/data", 32'({wr_addr, wr_data}), 32'd0);
      check("reset usr_rdata", 32'(usr_rdata), 32'd0);
    end else begin
      if (model_sync) check("usr_rdata", 32'(usr_rdata), 32'(model_regs[usr_raddr]));
      if (wr_strobe) begin
        check("wr_strobe expected", 32'(wr_q.size() > 0), 32'd1);
        check("wr_strobe width", 32'(prev_strobe), 32'd0);
        if (wr_q.size() > 0) check("wr_addr/data", 32'({wr_addr, wr_data}),
                                   32'(wr_q.pop_front()));
      end
    end
    prev_strobe = wr_strobe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] a;
    logic       s;
    int         n;
    model_regs = '{default: 8'h00};
    #1 rst_n = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(5);
    check_reg(4'd0, 8'h00, "reset reg0");
    check_reg(4'd15, 8'h00, "reset reg15");

    // Single write at pointer 3.
    buf_q = '{8'hAA};
    do_write(8'h03);
    check_reg(4'd3, 8'hAA, "write reg3");

    // Burst write that wraps past the top of the file.
    buf_q = '{8'h11, 8'h22, 8'h33};
    do_write(8'h0E);
    check_reg(4'd14, 8'h11, "wrap reg14");
    check_reg(4'd15, 8'h22, "wrap reg15");
    check_reg(4'd0, 8'h33, "wrap reg0");

    // Random read of pointer 3, single byte with NACK.
    do_read(1'b1, 8'h03, 1);
    check("random read byte", 32'(rd_log[0]), 32'hAA);

    // Burst read across the wrap.
    do_read(1'b1, 8'h0E, 3);
    check("burst read 0", 32'(rd_log[0]), 32'h11);
    check("burst read 1", 32'(rd_log[1]), 32'h22);
    check("burst read 2", 32'(rd_log[2]), 32'h33);

    // Address mismatch (0xA0 write byte).
    do_nomatch(7'h50, 1'b0);
    check_reg(4'd3, 8'hAA, "nomatch reg3 kept");

    // Reset during the pointer ACK.
    mstart();
    send_byte({Addr, 1'b0}, 1'b1, 1'b0, "rst addr");
    for (int i = 0; i < 8; i++) mbit((i == 5 || i == 7) ? 1'b1 : 1'b0, s);
    m_sda = 1'b1;
    tick(8);
    m_scl = 1'b1;
    tick(3);
    check("ptr ack driven", 32'(sda_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset sda_oe", 32'(sda_oe), 32'd0);
    model_regs = '{default: 8'h00};
    model_ptr = 4'd0;
    wr_q.delete();
    tick(4);
    rst_n = 1'b1;
    tick(6);
    buf_q = '{8'h5A};
    do_write(8'h07);
    check_reg(4'd7, 8'h5A, "post-reset write");
    check_reg(4'd3, 8'h00, "post-reset reg3 cleared");

    // Randomized traffic.
    for (int t = 0; t < 14; t++) begin
      case ($urandom_range(0, 3))
        0: begin
          buf_q.delete();
          n = int'($urandom_range(1, 4));
          for (int k = 0; k < n; k++) buf_q.push_back(8'($urandom));
          do_write(8'($urandom));
        end
        1: do_read(1'b1, 8'($urandom), int'($urandom_range(1, 4)));
        2: do_read(1'b0, 8'h00, int'($urandom_range(1, 3)));
        default: begin
          a = 7'($urandom);
          if (a == Addr) a = a ^ 7'h01;
          do_nomatch(a, 1'($urandom));
        end
      endcase
    end

    for (int k = 0; k < 16; k++) check_reg(4'(k), model_regs[k], "final regs");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Synthesizable I2C slave with an internal byte register file, sitting directly downstream of the I2C master on the shared SCL/SDA bus. It decodes START/STOP, matches its 7-bit device address, and serves register-pointer writes, burst data writes and burst reads with auto-increment, using the same framing the master produces for EEPROM-style random access. A user-side read port and write-strobe outputs expose the register contents to the rest of the design.

## Interface
- `SLAVE_ADDR`, default 7'h3C: 7-bit device address the block answers to.
- `AW`, default 4: register-file address width; depth is 2^AW bytes.
- `clk`  input  1  system clock; must be at least 8x the SCL frequency.
- `rst_n`  input  1  asynchronous, active-low reset.
- `scl_i`  input  1  raw SCL from the bus; asynchronous.
- `sda_i`  input  1  raw SDA from the bus; asynchronous.
- `sda_oe`  output  1  1 = pull SDA low (open drain); 0 = release.
- `busy`  output  1  high from a matched address ACK until STOP.
- `wr_strobe`  output  1  one-cycle pulse per data byte written to the file.
- `wr_addr`  output  AW  register address of the byte just written; valid with `wr_strobe`.
- `wr_data`  output  8  data of the byte just written; valid with `wr_strobe`.
- `usr_raddr`  input  AW  user read address.
- `usr_rdata`  output  8  combinational read of `regs[usr_raddr]`.

## Operation

**Input conditioning**
- `scl_i` and `sda_i` each pass through a 2-FF synchronizer, then a history register.
- `scl_rise`, `scl_fall`, `sda_rise` and `sda_fall` are decoded from the synced value and its history.
- START = `sda_fall` while SCL is high. STOP = `sda_rise` while SCL is high.

**Bit timing**
- Bits are sampled on `scl_rise`.
- `sda_oe` changes only on `scl_fall`, except for reset and STOP.

**States**
- IDLE: wait for START → ADDR.
- ADDR: shift in 8 bits, MSB first.
  - If bits[7:1] == `SLAVE_ADDR`, go to ADDR_ACK.
  - Otherwise go to IGNORE.
- ADDR_ACK: drive ACK for one SCL period.
  - R/W = 0 → PTR.
  - R/W = 1 → RDATA, loading the shift register with `regs[ptr]`.
- PTR: shift in 8 bits. `ptr` takes the low `AW` bits (wraps modulo 2^AW). → PTR_ACK → WDATA.
- WDATA: shift in 8 bits.
  - On the 8th `scl_rise`: write `regs[ptr]`, pulse `wr_strobe`, then `ptr <= ptr + 1` (wraps).
  - → WDATA_ACK → WDATA.
- RDATA: drive the shift-register MSB on each `scl_fall`; `sda_oe = ~bit`. After 8 bits, release SDA and go to RACK.
- RACK: sample the master's ACK on `scl_rise`.
  - ACK (SDA = 0): `ptr++`, load `regs[ptr]`, → RDATA.
  - NACK: → IGNORE.
- IGNORE: `sda_oe = 0` until STOP or START.

**ACK timing**
- `sda_oe` goes to 1 on the `scl_fall` after the 8th bit.
- It goes back to 0 on the next `scl_fall`.

**Overrides from any state**
- START → ADDR. This is a repeated start: `ptr` is retained, which enables random read.
- STOP → IDLE with `sda_oe` = 0.

**Reset values**
- `sda_oe` = 0, `busy` = 0, `wr_strobe` = 0, `wr_addr` = 0, `wr_data` = 0.
- `ptr` = 0, all `regs` = 8'h00, state = IDLE.

## Timing
- Edge detection latency is 3 `clk` cycles from a pin transition.
- SCL high and low phases must each be ≥ 4 `clk` cycles.
- `sda_oe` updates on the `clk` edge after the detected `scl_fall`, which is well within SCL low.
- `wr_strobe` asserts for exactly 1 cycle, in the cycle after the 8th data-bit `scl_rise` is detected.
- `usr_rdata` has zero latency.
  - A same-cycle write and user read of the same address returns the old value.
  - The new value is visible on the next cycle.
- SDA transitions while SCL is high, other than START/STOP, cannot occur in legal traffic. START/STOP detection takes priority over bit sampling.
- Reset asserted mid-transfer: `sda_oe` drops asynchronously and the slave is idle until the next START. A master-side NACK is the expected outcome.

## Test plan
- Write 0x3C+W, ptr 0x03, data 0xAA → ACK on all three bytes; `wr_strobe` once with `wr_addr` = 3, `wr_data` = 0xAA; `usr_raddr` = 3 reads 0xAA.
- Write ptr 0x0E, data 0x11 0x22 0x33 → `regs[E]` = 0x11, `regs[F]` = 0x22, `regs[0]` = 0x33 (wrap); three `wr_strobe` pulses.
- Random read: START 0x3C+W, ptr 0x03, repeated START 0x3C+R, master NACK → SDA carries 0xAA MSB-first; `sda_oe` released after NACK; `busy` falls at STOP.
- Burst read from ptr 0x0E with ACK, ACK, NACK → bytes 0x11, 0x22, 0x33.
- Address 0xA0+W (mismatch) → no ACK (`sda_oe` stays 0); `regs` unchanged; `busy` stays 0.
- Assert `rst_n` low during the ACK of the ptr byte → `sda_oe` = 0 immediately; after release, a new 0x3C+W transaction is ACKed normally.
